// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register map and shared helpers for the GPIO interrupt peripheral
package gpio_pkg;

    localparam int GPIO_REG_ADDR_W = 12;
    localparam int GPIO_BE_W       = 4;

    localparam logic [11:0] GPIO_OUT_REG          = 12'h000;
    localparam logic [11:0] GPIO_IN_REG           = 12'h004;
    localparam logic [11:0] GPIO_IN_DBNC_REG      = 12'h008;
    localparam logic [11:0] GPIO_INTR_EN_RISE_REG = 12'h00C;
    localparam logic [11:0] GPIO_INTR_EN_FALL_REG = 12'h010;
    localparam logic [11:0] GPIO_INTR_STATE_REG   = 12'h014;
    localparam logic [11:0] GPIO_DBNC_LIMIT_REG   = 12'h018;

    // Expands byte enables into a per-bit write mask.
    function automatic logic [31:0] gpio_be_mask(input logic [GPIO_BE_W-1:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/gpio_intr_dbnc_chan.sv
// rtl/gpio_intr_dbnc_chan.sv - per-pin synchroniser, debouncer and edge pulse generator
module gpio_dbnc_chan
    import gpio_pkg::*;
#(
    parameter int SyncStages = 2,
    parameter int CntWidth   = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pin_i,
    input  logic [CntWidth-1:0] limit_i,
    output logic                sync_o,
    output logic                dbnc_o,
    output logic                rise_o,
    output logic                fall_o
);

    logic [SyncStages-1:0] sync_q;
    logic [CntWidth-1:0]   cnt_q;
    logic [CntWidth-1:0]   last_cnt;
    logic                  dbnc_q;
    logic                  dbnc_d_q;

    assign sync_o = sync_q[SyncStages-1];

    // A limit of 0 behaves like 1: commit on the first differing cycle.
    assign last_cnt = (limit_i == '0) ? '0 : limit_i - CntWidth'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            dbnc_q   <= 1'b0;
            dbnc_d_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SyncStages-2:0], pin_i};
            dbnc_d_q <= dbnc_q;
            if (sync_o == dbnc_q) begin
                cnt_q <= '0;
            end else if (cnt_q >= last_cnt) begin
                dbnc_q <= sync_o;
                cnt_q  <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end
        end
    end

    assign dbnc_o = dbnc_q;
    assign rise_o = dbnc_q & ~dbnc_d_q;
    assign fall_o = ~dbnc_q & dbnc_d_q;

endmodule

// File: rtl/gpio_intr.sv
// rtl/gpio_intr.sv - GPIO peripheral with masked outputs, debounced inputs and edge interrupts
module gpio_intr
    import gpio_pkg::*;
#(
    parameter int GpiWidth   = 8,
    parameter int GpoWidth   = 16,
    parameter int AddrWidth  = 32,
    parameter int DataWidth  = 32,
    parameter int RegAddr    = GPIO_REG_ADDR_W,
    parameter int CntWidth   = 16,
    parameter int DbncReset  = 500,
    parameter int SyncStages = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 device_req_i,
    input  logic [AddrWidth-1:0] device_addr_i,
    input  logic                 device_we_i,
    input  logic [3:0]           device_be_i,
    input  logic [DataWidth-1:0] device_wdata_i,
    output logic                 device_rvalid_o,
    output logic [DataWidth-1:0] device_rdata_o,
    input  logic [GpiWidth-1:0]  gp_i,
    output logic [GpoWidth-1:0]  gp_o,
    output logic                 irq_o
);

    logic [GpiWidth-1:0]  gp_sync, gp_dbnc, rise, fall;
    logic [GpoWidth-1:0]  out_q;
    logic [GpiWidth-1:0]  en_rise_q, en_fall_q, intr_state_q;
    logic [GpiWidth-1:0]  intr_set, intr_clr;
    logic [CntWidth-1:0]  limit_q;
    logic                 irq_q, rvalid_q;
    logic [DataWidth-1:0] rdata_q, rd_mux, be_mask;
    logic [RegAddr-1:0]   reg_addr;
    logic                 wr_en, rd_en;
    logic                 wr_out, wr_en_rise, wr_en_fall, wr_state, wr_limit;
    logic                 unused_bits;

    for (genvar i = 0; i < GpiWidth; i++) begin : g_chan
        gpio_dbnc_chan #(
            .SyncStages(SyncStages),
            .CntWidth  (CntWidth)
        ) u_chan (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .pin_i  (gp_i[i]),
            .limit_i(limit_q),
            .sync_o (gp_sync[i]),
            .dbnc_o (gp_dbnc[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

    assign reg_addr   = device_addr_i[RegAddr-1:0];
    assign wr_en      = device_req_i & device_we_i;
    assign rd_en      = device_req_i & ~device_we_i;
    assign be_mask    = DataWidth'(gpio_be_mask(device_be_i));
    assign wr_out     = wr_en && (reg_addr == RegAddr'(GPIO_OUT_REG));
    assign wr_en_rise = wr_en && (reg_addr == RegAddr'(GPIO_INTR_EN_RISE_REG));
    assign wr_en_fall = wr_en && (reg_addr == RegAddr'(GPIO_INTR_EN_FALL_REG));
    assign wr_state   = wr_en && (reg_addr == RegAddr'(GPIO_INTR_STATE_REG));
    assign wr_limit   = wr_en && (reg_addr == RegAddr'(GPIO_DBNC_LIMIT_REG));

    assign intr_set = (rise & en_rise_q) | (fall & en_fall_q);
    assign intr_clr = wr_state ? (device_wdata_i[GpiWidth-1:0] & be_mask[GpiWidth-1:0]) : '0;

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            RegAddr'(GPIO_OUT_REG):          rd_mux = DataWidth'(out_q);
            RegAddr'(GPIO_IN_REG):           rd_mux = DataWidth'(gp_sync);
            RegAddr'(GPIO_IN_DBNC_REG):      rd_mux = DataWidth'(gp_dbnc);
            RegAddr'(GPIO_INTR_EN_RISE_REG): rd_mux = DataWidth'(en_rise_q);
            RegAddr'(GPIO_INTR_EN_FALL_REG): rd_mux = DataWidth'(en_fall_q);
            RegAddr'(GPIO_INTR_STATE_REG):   rd_mux = DataWidth'(intr_state_q);
            RegAddr'(GPIO_DBNC_LIMIT_REG):   rd_mux = DataWidth'(limit_q);
            default:                         rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q        <= '0;
            en_rise_q    <= '0;
            en_fall_q    <= '0;
            intr_state_q <= '0;
            limit_q      <= CntWidth'(DbncReset);
            irq_q        <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            if (wr_out)
                out_q <= (out_q & ~be_mask[GpoWidth-1:0]) | (device_wdata_i[GpoWidth-1:0] & be_mask[GpoWidth-1:0]);
            if (wr_en_rise)
                en_rise_q <= (en_rise_q & ~be_mask[GpiWidth-1:0]) | (device_wdata_i[GpiWidth-1:0] & be_mask[GpiWidth-1:0]);
            if (wr_en_fall)
                en_fall_q <= (en_fall_q & ~be_mask[GpiWidth-1:0]) | (device_wdata_i[GpiWidth-1:0] & be_mask[GpiWidth-1:0]);
            if (wr_limit)
                limit_q <= (limit_q & ~be_mask[CntWidth-1:0]) | (device_wdata_i[CntWidth-1:0] & be_mask[CntWidth-1:0]);
            // Hardware set is applied after the clear so a coincident event is never lost.
            intr_state_q <= (intr_state_q & ~intr_clr) | intr_set;
            irq_q        <= |intr_state_q;
            rvalid_q     <= device_req_i;
            rdata_q      <= rd_en ? rd_mux : '0;
        end
    end

    assign gp_o            = out_q;
    assign irq_o           = irq_q;
    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;

    assign unused_bits = ^{device_addr_i[AddrWidth-1:RegAddr], device_wdata_i, be_mask};

endmodule

// File: tb/tb_gpio_intr.sv
// tb/tb_gpio_intr.sv - self-checking bench for gpio_intr
module tb_gpio_intr;

    localparam logic [31:0] A_OUT   = 32'h00;
    localparam logic [31:0] A_IN    = 32'h04;
    localparam logic [31:0] A_DBNC  = 32'h08;
    localparam logic [31:0] A_ENR   = 32'h0C;
    localparam logic [31:0] A_ENF   = 32'h10;
    localparam logic [31:0] A_STATE = 32'h14;
    localparam logic [31:0] A_LIMIT = 32'h18;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [15:0] exp_gpo;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        rvalid;
    logic [31:0] rdata;
    logic [7:0]  gp_i = '0;
    logic [15:0] gp_o;
    logic        irq;
    logic        chk_en = 1'b0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    gpio_intr dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .device_req_i   (req),
        .device_addr_i  (addr),
        .device_we_i    (we),
        .device_be_i    (be),
        .device_wdata_i (wdata),
        .device_rvalid_o(rvalid),
        .device_rdata_o (rdata),
        .gp_i           (gp_i),
        .gp_o           (gp_o),
        .irq_o          (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registers as plain variables, debounce judged from a window of past synced samples.
    logic [7:0]  m_pipe0, m_pipe1, m_dbnc, m_dbnc_d, m_state, m_en_r, m_en_f;
    logic [15:0] m_out, m_limit;
    logic        m_irq, m_rv;
    logic [31:0] m_rd;
    logic [7:0]  m_hist[$];

    task automatic model_reset();
        m_pipe0 = '0; m_pipe1 = '0; m_dbnc = '0; m_dbnc_d = '0; m_state = '0;
        m_en_r = '0; m_en_f = '0; m_out = '0; m_limit = 16'd500;
        m_irq = 1'b0; m_rv = 1'b0; m_rd = '0;
        m_hist.delete();
    endtask

    task automatic model_step();
        logic [7:0]  sync_now, set, clr, n_dbnc, n_state;
        logic [31:0] mask, nrd;
        logic [11:0] a;
        int          need;
        bit          all_diff;
        a = addr[11:0];
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        sync_now = m_pipe1;
        nrd = '0;
        if (req && !we) begin
            case (a)
                12'h000: nrd = {16'h0, m_out};
                12'h004: nrd = {24'h0, sync_now};
                12'h008: nrd = {24'h0, m_dbnc};
                12'h00C: nrd = {24'h0, m_en_r};
                12'h010: nrd = {24'h0, m_en_f};
                12'h014: nrd = {24'h0, m_state};
                12'h018: nrd = {16'h0, m_limit};
                default: nrd = '0;
            endcase
        end
        set = (m_dbnc & ~m_dbnc_d & m_en_r) | (~m_dbnc & m_dbnc_d & m_en_f);
        clr = (req && we && a == 12'h014) ? (wdata[7:0] & mask[7:0]) : 8'h00;
        n_state = (m_state & ~clr) | set;
        m_hist.push_front(sync_now);
        if (m_hist.size() > 1024) void'(m_hist.pop_back());
        need = (m_limit == 16'd0) ? 1 : int'(m_limit);
        n_dbnc = m_dbnc;
        for (int p = 0; p < 8; p++) begin
            if (m_hist.size() >= need) begin
                all_diff = 1'b1;
                for (int k = 0; k < need; k++) begin
                    if (m_hist[k][p] == m_dbnc[p]) begin
                        all_diff = 1'b0;
                        break;
                    end
                end
                if (all_diff) n_dbnc[p] = sync_now[p];
            end
        end
        if (req && we) begin
            case (a)
                12'h000: m_out   = (m_out & ~mask[15:0]) | (wdata[15:0] & mask[15:0]);
                12'h00C: m_en_r  = (m_en_r & ~mask[7:0]) | (wdata[7:0] & mask[7:0]);
                12'h010: m_en_f  = (m_en_f & ~mask[7:0]) | (wdata[7:0] & mask[7:0]);
                12'h018: m_limit = (m_limit & ~mask[15:0]) | (wdata[15:0] & mask[15:0]);
                default: ;
            endcase
        end
        m_irq    = |m_state;
        m_state  = n_state;
        m_dbnc_d = m_dbnc;
        m_dbnc   = n_dbnc;
        m_rv     = req;
        m_rd     = nrd;
        m_pipe1  = m_pipe0;
        m_pipe0  = gp_i;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cyc_rvalid", {31'h0, rvalid}, {31'h0, m_rv});
                check("cyc_rdata", rdata, m_rd);
                check("cyc_gpo", {16'h0, gp_o}, {16'h0, m_out});
                check("cyc_irq", {31'h0, irq}, {31'h0, m_irq});
            end
        end
    end

    task automatic bus(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d,
                       output logic [31:0] rd, output logic rv);
        @(negedge clk);
        req = 1'b1; addr = a; we = w; be = b; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        rv = rvalid;
        rd = rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] rd;
        logic        rv;
        bus(a, 1'b1, b, d, rd, rv);
        check("wr_rvalid", {31'h0, rv}, 32'h1);
        check("wr_rdata", rd, 32'h0);
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
        logic rv;
        bus(a, 1'b0, 4'h0, 32'h0, d, rv);
        check("rd_rvalid", {31'h0, rv}, 32'h1);
    endtask

    task automatic first_rise(input logic [31:0] a, input logic [7:0] gp_val, output int first);
        first = -1;
        @(negedge clk);
        gp_i = gp_val; req = 1'b1; we = 1'b0; addr = a;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (first < 0 && rdata[0]) first = i;
        end
        req = 1'b0;
    endtask

    task automatic glitch(input int len, output logic saw_low);
        saw_low = 1'b0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = A_DBNC; gp_i[0] = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == len) gp_i[0] = 1'b1;
            if (!rdata[0]) saw_low = 1'b1;
        end
        req = 1'b0;
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] rd;
        logic        rv;
        int          first;
        logic        saw;
        int          idx;

        repeat (3) @(negedge clk);
        check("rst_gpo", {16'h0, gp_o}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_rvalid", {31'h0, rvalid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;
        rd_reg(A_LIMIT, rd);
        check("rst_limit", rd, 32'd500);

        vecs.push_back('{A_OUT,   1'b1, 4'b0011, 32'h0000_A5C3, 32'h0,       16'hA5C3});
        vecs.push_back('{A_OUT,   1'b1, 4'b0001, 32'h0000_FFFF, 32'h0,       16'hA5FF});
        vecs.push_back('{A_OUT,   1'b0, 4'b0000, 32'h0,         32'h0000_A5FF, 16'hA5FF});
        vecs.push_back('{A_OUT,   1'b1, 4'b1100, 32'h1234_5678, 32'h0,       16'hA5FF});
        vecs.push_back('{A_ENR,   1'b1, 4'b1111, 32'hFFFF_FF5A, 32'h0,       16'hA5FF});
        vecs.push_back('{A_ENR,   1'b0, 4'b0000, 32'h0,         32'h0000_005A, 16'hA5FF});
        vecs.push_back('{A_ENR,   1'b1, 4'b0001, 32'h0,         32'h0,       16'hA5FF});
        vecs.push_back('{A_LIMIT, 1'b1, 4'b0010, 32'hABCD_1234, 32'h0,       16'hA5FF});
        vecs.push_back('{32'hFFFF_F018, 1'b0, 4'b0000, 32'h0,   32'h0000_12F4, 16'hA5FF});
        vecs.push_back('{32'h1C,  1'b0, 4'b0000, 32'h0,         32'h0,       16'hA5FF});
        vecs.push_back('{32'h20,  1'b0, 4'b0000, 32'h0,         32'h0,       16'hA5FF});
        vecs.push_back('{A_DBNC,  1'b0, 4'b0000, 32'h0,         32'h0,       16'hA5FF});
        vecs.push_back('{A_STATE, 1'b0, 4'b0000, 32'h0,         32'h0,       16'hA5FF});
        vecs.push_back('{A_LIMIT, 1'b1, 4'b1111, 32'h4,         32'h0,       16'hA5FF});
        vecs.push_back('{A_LIMIT, 1'b0, 4'b0000, 32'h0,         32'h4,       16'hA5FF});
        foreach (vecs[i]) begin
            bus(vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata, rd, rv);
            check($sformatf("vec%0d_rvalid", i), {31'h0, rv}, 32'h1);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_gpo", i), {16'h0, gp_o}, {16'h0, vecs[i].exp_gpo});
        end
        @(negedge clk);
        check("rvalid_single", {31'h0, rvalid}, 32'h0);

        first_rise(A_IN, 8'h01, first);
        check("in_latency", first, 3);
        gp_i = 8'h00;
        repeat (20) @(negedge clk);
        first_rise(A_DBNC, 8'h01, first);
        check("dbnc_latency", first, 7);
        glitch(3, saw);
        check("glitch3_ignored", {31'h0, saw}, 32'h0);
        glitch(4, saw);
        check("glitch4_seen", {31'h0, saw}, 32'h1);
        repeat (10) @(negedge clk);

        wr(A_LIMIT, 32'd2, 4'hF);
        gp_i = 8'h02;
        repeat (12) @(negedge clk);
        wr(A_STATE, 32'hFF, 4'hF);
        wr(A_ENR, 32'h01, 4'hF);
        wr(A_ENF, 32'h02, 4'hF);
        gp_i = 8'h01;
        repeat (12) @(negedge clk);
        rd_reg(A_STATE, rd);
        check("intr_both", rd, 32'h3);
        check("irq_set", {31'h0, irq}, 32'h1);
        wr(A_ENR, 32'h00, 4'hF);
        rd_reg(A_STATE, rd);
        check("intr_kept_after_disable", rd, 32'h3);
        wr(A_STATE, 32'h01, 4'hF);
        rd_reg(A_STATE, rd);
        check("w1c_bit0", rd, 32'h2);
        check("irq_still", {31'h0, irq}, 32'h1);
        wr(A_STATE, 32'h02, 4'hF);
        rd_reg(A_STATE, rd);
        check("w1c_bit1", rd, 32'h0);
        check("irq_clear", {31'h0, irq}, 32'h0);

        wr(A_LIMIT, 32'd0, 4'hF);
        rd_reg(A_LIMIT, rd);
        check("limit_zero", rd, 32'h0);
        rd_reg(32'h1C, rd);
        check("unmapped_1c", rd, 32'h0);
        wr(A_ENR, 32'h01, 4'hF);
        gp_i = 8'h00;
        repeat (6) @(negedge clk);
        first_rise(A_DBNC, 8'h01, first);
        check("bypass_latency", first, 4);
        rd_reg(A_STATE, rd);
        check("bypass_rise_intr", rd, 32'h1);
        gp_i[0] = 1'b0;
        repeat (6) @(negedge clk);
        @(negedge clk);
        gp_i[0] = 1'b1;
        repeat (3) @(negedge clk);
        req = 1'b1; we = 1'b1; addr = A_STATE; be = 4'b0001; wdata = 32'h1;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        check("set_wins_irq0", {31'h0, irq}, 32'h1);
        @(negedge clk);
        check("set_wins_irq1", {31'h0, irq}, 32'h1);
        rd_reg(A_STATE, rd);
        check("set_wins_state", rd, 32'h1);

        wr(A_OUT, 32'h1234, 4'b0011);
        wr(A_LIMIT, 32'd50, 4'hF);
        gp_i = 8'h02;
        repeat (5) @(negedge clk);
        req = 1'b1; we = 1'b0; addr = A_OUT;
        @(negedge clk);
        req = 1'b0;
        check("pre_rst_rvalid", {31'h0, rvalid}, 32'h1);
        check("pre_rst_rdata", rdata, 32'h1234);
        check("pre_rst_irq", {31'h0, irq}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_gpo", {16'h0, gp_o}, 32'h0);
        check("async_rst_irq", {31'h0, irq}, 32'h0);
        check("async_rst_rvalid", {31'h0, rvalid}, 32'h0);
        check("async_rst_rdata", rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        gp_i = 8'h00;
        rd_reg(A_LIMIT, rd);
        check("post_rst_limit", rd, 32'd500);
        rd_reg(A_STATE, rd);
        check("post_rst_state", rd, 32'h0);

        wr(A_LIMIT, 32'd3, 4'hF);
        wr(A_ENR, 32'h0F, 4'hF);
        wr(A_ENF, 32'hF0, 4'hF);
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) gp_i = gp_i ^ (8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) begin
                idx = $urandom_range(0, 8);
                addr = {($urandom_range(0, 1) == 1) ? 20'hABCDE : 20'h00000, 12'(idx * 4)};
                we = 1'($urandom_range(0, 1));
                be = 4'($urandom_range(0, 15));
                wdata = $urandom;
                if (idx == 6) wdata = 32'($urandom_range(0, 6));
                req = 1'b1;
            end else begin
                req = 1'b0;
                we = 1'b0;
            end
        end
        @(negedge clk);
        req = 1'b0;
        we = 1'b0;
        repeat (10) @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
